div_unit: RTL

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 94 +++++++++
 1 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring radix-2 divider (DIV/DIVU/REM/REMU) for an in-order execute stage
//   Ports: clk, rst_n (async, active-low)
//          start        in  1  op present in execute (held while it occupies execute)
//          op           in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU
//          a, b         in 32  dividend, divisor (sampled on acceptance)
//          hazard_stall in  1  downstream frozen; hold a completed result
//          result       out 32 registered quotient/remainder
//          stall        out 1  execute must hold (combinational)
//          done         out 1  result valid this cycle
//   Option: define DIV_FAST_SPECIAL_EN to finish divide-by-zero and signed overflow in one cycle.
module div_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        hazard_stall,
   output logic [31:0] result,
   output logic        stall,
   output logic        done
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t      r_state, w_next;
   logic [31:0] r_rem, r_quo, r_div, r_result;
   logic [4:0]  r_cnt;
   logic        r_rem_op, r_neg_q, r_neg_r;
   logic        w_signed, w_accept, w_ge, w_special;
   logic [31:0] w_abs_a, w_abs_b, w_rem_n, w_quo_n, w_final, w_spec_res;
   logic [32:0] w_sh;
   logic [33:0] w_sub;
   assign w_signed = ~op[0];
   assign w_accept = (r_state == IDLE) && start;
   assign w_abs_a  = (w_signed && a[31]) ? -a : a;
   assign w_abs_b  = (w_signed && b[31]) ? -b : b;
   // 34-bit subtract: the shifted partial remainder can exceed 32 bits
   assign w_sh     = {r_rem, r_quo[31]};
   assign w_sub    = {1'b0, w_sh} - {2'b0, r_div};
   assign w_ge     = ~w_sub[33];
   assign w_rem_n  = w_ge ? w_sub[31:0] : w_sh[31:0];
   assign w_quo_n  = {r_quo[30:0], w_ge};
   // A zero divisor yields an all-ones magnitude quotient and |a| remainder; quotient negation
   // is suppressed for it and the remainder sign restore gives back a exactly.
   assign w_final  = r_rem_op ? (r_neg_r ? -w_rem_n : w_rem_n) : (r_neg_q ? -w_quo_n : w_quo_n);
`ifdef DIV_FAST_SPECIAL_EN
   assign w_special  = (b == 32'h0) || (w_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
   assign w_spec_res = (b == 32'h0) ? (op[1] ? a : 32'hFFFF_FFFF) : (op[1] ? 32'h0 : 32'h8000_0000);
`else
   assign w_special  = 1'b0;
   assign w_spec_res = 32'h0;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? (w_special ? DONE : BUSY) : IDLE;
         BUSY:    w_next = !start ? IDLE : (r_cnt == 5'd0 ? DONE : BUSY);
         DONE:    w_next = hazard_stall ? DONE : IDLE;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rem    <= '0;
         r_quo    <= '0;
         r_div    <= '0;
         r_cnt    <= '0;
         r_rem_op <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_rem    <= '0;
         r_quo    <= w_abs_a;
         r_div    <= w_abs_b;
         r_cnt    <= 5'd31;
         r_rem_op <= op[1];
         r_neg_r  <= w_signed && a[31];
         r_neg_q  <= w_signed && (a[31] ^ b[31]) && (b != 32'h0);
         if (w_special) r_result <= w_spec_res;
      end else if (r_state == BUSY) begin
         r_rem <= w_rem_n;
         r_quo <= w_quo_n;
         r_cnt <= r_cnt - 5'd1;
         if (start && r_cnt == 5'd0) r_result <= w_final;
      end
   end
   assign result = r_result;
   assign done   = (r_state == DONE);
   assign stall  = rst_n && (w_accept || r_state == BUSY);
endmodule
